axis_pkt_gen_chk: RTL and testbench



---
 rtl/axis_pkt_gen_chk.sv | 194 +++++++++++++++++++
 tb/tb_axis_pkt_gen_chk.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen_chk.sv
// axis_pkt_gen_chk: AXI4-Stream traffic generator and checker for bring-up.
// A start pulse sends one packet of C_PKT_WORDS incrementing words (seed,
// seed+1, ...) on the master port. The returned packet on the slave port is
// then compared against the same pattern.
//
// Ports:
//   AXIS_ACLK, AXIS_ARESET   clock, asynchronous active-high reset
//   start, seed              run request (accepted in IDLE), first pattern word
//   busy, done               run in progress, one-cycle end-of-run pulse
//   pass, err_count,         result of the last run: overall pass, data
//   tlast_err, timeout         mismatches + missing words, framing error, timeout
//   M_AXIS_*                 generated packet
//   S_AXIS_*                 returned packet (TSTRB ignored)
module axis_pkt_gen_chk #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_PKT_WORDS        = 8,
  parameter int unsigned C_START_COUNT      = 32,
  parameter int unsigned C_TIMEOUT          = 1024
) (
  input  logic                                AXIS_ACLK,
  input  logic                                AXIS_ARESET,
  input  logic                                start,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]       seed,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic [$clog2(C_PKT_WORDS+1)-1:0]    err_count,
  output logic                                tlast_err,
  output logic                                timeout,
  output logic                                M_AXIS_TVALID,
  output logic [C_AXIS_TDATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]     M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  output logic                                S_AXIS_TREADY,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]       S_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]     S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID
);

  localparam int unsigned DW    = C_AXIS_TDATA_WIDTH;
  localparam int unsigned IdxW  = $clog2(C_PKT_WORDS);
  localparam int unsigned CntW  = $clog2(C_PKT_WORDS + 1);
  localparam int unsigned WaitW = $clog2(C_START_COUNT + 2);
  localparam int unsigned TmoW  = $clog2(C_TIMEOUT + 1);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(C_PKT_WORDS - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWait = 3'd1;
  localparam logic [2:0] StSend = 3'd2;
  localparam logic [2:0] StRecv = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [DW-1:0]   seed_q, seed_d;
  logic [IdxW-1:0] idx_q, idx_d;     // tx index in SEND, rx index in RECV
  logic [WaitW-1:0] wait_q, wait_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [CntW-1:0] err_q, err_d;
  logic            tlast_err_q, tlast_err_d;
  logic            timeout_q, timeout_d;
  logic            pass_q, pass_d;

  logic [DW-1:0]   pattern;
  logic            mismatch;
  logic            unused_tstrb;

  assign unused_tstrb = ^S_AXIS_TSTRB;

  assign pattern  = seed_q + DW'(idx_q);
  assign mismatch = (S_AXIS_TDATA != pattern);

  function automatic logic [CntW-1:0] sat_add(input logic [CntW-1:0] a,
                                               input logic [CntW-1:0] b);
    logic [CntW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CntW] ? {CntW{1'b1}} : sum[CntW-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    tlast_err_d = tlast_err_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          seed_d      = seed;
          idx_d       = '0;
          wait_d      = '0;
          tmo_d       = '0;
          err_d       = '0;
          tlast_err_d = 1'b0;
          timeout_d   = 1'b0;
          pass_d      = 1'b0;
          state_d     = (C_START_COUNT == 0) ? StSend : StWait;
        end
      end
      StWait: begin
        if (wait_q == WaitW'(C_START_COUNT - 1)) state_d = StSend;
        else                                      wait_d  = wait_q + 1'b1;
      end
      StSend: begin
        if (M_AXIS_TREADY) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            tmo_d   = '0;
            state_d = StRecv;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StRecv: begin
        if (S_AXIS_TVALID) begin
          tmo_d = '0;
          err_d = sat_add(err_q, CntW'(mismatch));
          if (idx_q == LastIdx) begin
            // Missing TLAST: excess words are left unconsumed on the bus.
            tlast_err_d = ~S_AXIS_TLAST;
            state_d     = StDone;
          end else if (S_AXIS_TLAST) begin
            // Early TLAST: the words never sent count as errors.
            tlast_err_d = 1'b1;
            err_d       = sat_add(sat_add(err_q, CntW'(mismatch)),
                                  CntW'(C_PKT_WORDS - 1) - CntW'(idx_q));
            state_d     = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tmo_q == TmoW'(C_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          err_d     = sat_add(err_q, CntW'(C_PKT_WORDS) - CntW'(idx_q));
          state_d   = StDone;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Result is computed on entry to DONE so pass is valid together with done.
    if (state_q == StRecv && state_d == StDone) begin
      pass_d = (err_d == '0) && !tlast_err_d && !timeout_d;
    end
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_q     <= StIdle;
      seed_q      <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      tmo_q       <= '0;
      err_q       <= '0;
      tlast_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      tlast_err_q <= tlast_err_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
    end
  end

  // Outputs decode directly from registers, so reset clears them immediately.
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign tlast_err     = tlast_err_q;
  assign timeout       = timeout_q;
  assign M_AXIS_TVALID = (state_q == StSend);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? pattern : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID && (idx_q == LastIdx);
  assign M_AXIS_TSTRB  = '1;
  assign S_AXIS_TREADY = (state_q == StRecv);

endmodule

// File: tb/tb_axis_pkt_gen_chk.sv
// Bench for axis_pkt_gen_chk: directed runs with a TX scoreboard, a return
// path model (loopback / corrupt / early TLAST / silent) and a result queue.
module tb_axis_pkt_gen_chk;

  localparam int DW = 32;
  localparam int N  = 8;
  localparam int SC = 4;
  localparam int TO = 40;
  localparam int CW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [DW-1:0]   seed = '0;
  logic            busy, done, pass, tlast_err, timeout;
  logic [CW-1:0]   err_count;
  logic            M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  logic [DW-1:0]   M_AXIS_TDATA;
  logic [DW/8-1:0] M_AXIS_TSTRB;
  logic            S_AXIS_TREADY, S_AXIS_TLAST, S_AXIS_TVALID;
  logic [DW-1:0]   S_AXIS_TDATA;
  logic [DW/8-1:0] S_AXIS_TSTRB;

  always #5 clk = ~clk;

  axis_pkt_gen_chk #(
    .C_AXIS_TDATA_WIDTH(DW),
    .C_PKT_WORDS       (N),
    .C_START_COUNT     (SC),
    .C_TIMEOUT         (TO)
  ) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESET  (rst),
    .start        (start),
    .seed         (seed),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .tlast_err    (tlast_err),
    .timeout      (timeout),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TSTRB (M_AXIS_TSTRB),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA (S_AXIS_TDATA),
    .S_AXIS_TSTRB (S_AXIS_TSTRB),
    .S_AXIS_TLAST (S_AXIS_TLAST),
    .S_AXIS_TVALID(S_AXIS_TVALID)
  );

  typedef struct {int er; bit tl; bit to; bit ps; int md;} res_t;
  typedef struct {logic [DW-1:0] d; bit l;} beat_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [DW-1:0] exp_tx[$];
  res_t          exp_res[$];
  beat_t         ret_q[$];

  // mode: 0 loopback, 1 corrupt idx 3 and 6, 2 TLAST on idx 4, 3 no return
  int            mode = 0;
  int            rmode = 0;   // 0 TREADY always on, 1 one on / two off
  logic [DW-1:0] cur_seed = '0;
  bit            s_fire_pend = 1'b0;
  int            last_s_cyc = 0, last_m_cyc = 0, start_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready and return-path driver, updated just after each edge.
  initial begin
    M_AXIS_TREADY = 1'b0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TSTRB  = '1;
    forever begin
      @(posedge clk);
      #1;
      if (s_fire_pend && ret_q.size() > 0) ret_q.delete(0);
      M_AXIS_TREADY = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (ret_q.size() > 0) begin
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = ret_q[0].d;
        S_AXIS_TLAST  = ret_q[0].l;
      end else begin
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TLAST  = 1'b0;
      end
    end
  end

  // Monitor: samples on the falling edge.
  logic [DW-1:0] e, held_d;
  bit            held_l, stall_q, prev_valid, prev_done;
  int            idx;
  res_t          r;
  beat_t         b;
  initial begin
    stall_q = 0; prev_valid = 0; prev_done = 0; held_d = '0; held_l = 0;
    forever begin
      @(negedge clk);
      s_fire_pend = S_AXIS_TVALID && S_AXIS_TREADY;
      if (s_fire_pend) last_s_cyc = cyc;
      if (start && !busy && !rst) start_cyc = cyc;
      if (M_AXIS_TVALID && !prev_valid) chk("first_tvalid_latency", cyc - start_cyc, SC + 1);
      if (stall_q) begin
        chk("tvalid_held", M_AXIS_TVALID, 1);
        chk("tdata_held", M_AXIS_TDATA, held_d);
        chk("tlast_held", M_AXIS_TLAST, held_l);
      end
      stall_q    = M_AXIS_TVALID && !M_AXIS_TREADY;
      held_d     = M_AXIS_TDATA;
      held_l     = M_AXIS_TLAST;
      prev_valid = M_AXIS_TVALID;

      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        last_m_cyc = cyc;
        if (exp_tx.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected: got %0h expected no beat", M_AXIS_TDATA);
        end else begin
          e   = exp_tx.pop_front();
          idx = int'(e - cur_seed);
          chk("tx_data", M_AXIS_TDATA, e);
          chk("tx_last", M_AXIS_TLAST, idx == N - 1);
          b.d = M_AXIS_TDATA;
          b.l = M_AXIS_TLAST;
          if (mode == 1 && (idx == 3 || idx == 6)) b.d = b.d ^ 32'h1;
          if (mode == 2 && idx == 4) b.l = 1'b1;
          if (mode != 3) ret_q.push_back(b);
        end
      end

      if (prev_done) chk("busy_after_done", busy, 0);
      prev_done = done;
      if (done) begin
        if (exp_res.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: got done expected none");
        end else begin
          r = exp_res.pop_front();
          chk("err_count", err_count, r.er);
          chk("tlast_err", tlast_err, r.tl);
          chk("timeout", timeout, r.to);
          chk("pass", pass, r.ps);
          chk("busy_in_done", busy, 1);
          if (r.md == 3) chk("done_cycle_timeout", cyc, last_m_cyc + 1 + TO);
          else           chk("done_cycle", cyc, last_s_cyc + 1);
        end
      end
    end
  end

  task automatic run(input logic [DW-1:0] sd, input int md, input int rm, input int er,
                     input bit tl, input bit to, input bit pre, input bit chain,
                     input logic [DW-1:0] nsd);
    res_t rr;
    bit   got;
    ret_q.delete();
    mode     = md;
    rmode    = rm;
    cur_seed = sd;
    for (int i = 0; i < N; i++) exp_tx.push_back(sd + DW'(i));
    rr = '{er, tl, to, (er == 0 && !tl && !to), md};
    exp_res.push_back(rr);
    if (!pre) begin
      seed = sd;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 600 && !got; k++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL run_done_wait: got no done expected done within 600 cycles");
    end
    if (chain) begin
      // start held through DONE (ignored) and the next IDLE cycle (accepted)
      seed  = nsd;
      start = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 start = 1'b0;
    end else begin
      repeat (2) @(posedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", M_AXIS_TVALID, 0);
    chk("rst_tdata", M_AXIS_TDATA, 0);
    chk("rst_tstrb", M_AXIS_TSTRB, 4'hf);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_s_tready", S_AXIS_TREADY, 0);
    rst = 1'b0;

    run(32'h10, 0, 0, 0, 0, 0, 0, 1, 32'h20);
    run(32'h20, 0, 1, 0, 0, 0, 1, 0, '0);
    run(32'h30, 1, 0, 2, 0, 0, 0, 0, '0);
    run(32'h40, 2, 0, 3, 1, 0, 0, 0, '0);
    run(32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, 0, '0);
    run(32'h50, 3, 0, 8, 0, 1, 0, 0, '0);

    // Reset in the middle of SEND.
    mode = 0; rmode = 0; cur_seed = 32'h60; seed = 32'h60;
    for (int i = 0; i < N; i++) exp_tx.push_back(32'h60 + DW'(i));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 50 && !M_AXIS_TVALID; k++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_tvalid", M_AXIS_TVALID, 0);
    chk("async_rst_busy", busy, 0);
    exp_tx.delete();
    exp_res.delete();
    ret_q.delete();
    @(posedge clk); #1 rst = 1'b0;

    run(32'h70, 0, 0, 0, 0, 0, 0, 0, '0);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("res_queue_empty", exp_res.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
